// File: rtl/rsa_pkg.sv
// Shared RSA definitions: FSM states, default width, latency and datapath headroom.
// Used by the modular-exponentiation core and the key-generation multiplier path.
package rsa_pkg;

  localparam int RSA_W = 8;

  // Interleaved sums need two bits above the operand width (value < 2n + n)
  localparam int RSA_SUM_GUARD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQR  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } rsa_state_e;

  function automatic int rsa_latency(input int w);
    return 2 * w * w + 1;
  endfunction

  localparam int RSA_LATENCY = rsa_latency(RSA_W);

endpackage

// File: rtl/rsa_modexp_core_if.sv
// Request/response bundle for rsa_modexp_core; the err signal exists only
// when RSA_RANGE_CHECK_EN is defined.
interface rsa_modexp_core_if
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
);
  logic         start;
  logic [W-1:0] msg;
  logic [W-1:0] exp;
  logic [W-1:0] modulus;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef RSA_RANGE_CHECK_EN
  logic         err;

  modport master (output start, msg, exp, modulus, input busy, done, result, err);
  modport slave  (input start, msg, exp, modulus, output busy, done, result, err);
`else
  modport master (output start, msg, exp, modulus, input busy, done, result);
  modport slave  (input start, msg, exp, modulus, output busy, done, result);
`endif
endinterface

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: p = a*b mod n, one bit of b per cycle,
// MSB first. The first step runs on the start edge, so done rises W-1 cycles later.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         done,
  output logic [W-1:0] p
);
  localparam int SW = W + RSA_SUM_GUARD;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  p_reg, a_reg, b_reg, n_reg;
  logic [CW-1:0] cnt_reg;
  logic          done_reg;

  logic [W-1:0]  src_p, src_a, src_n, p_next;
  logic          src_bit;
  logic [SW-1:0] n_ext, dbl, red1, sum, red2;

  // On the start edge the step works on the fresh operands with a zero accumulator
  always_comb begin
    src_p   = start ? '0 : p_reg;
    src_a   = start ? a : a_reg;
    src_n   = start ? n : n_reg;
    src_bit = start ? b[W-1] : b_reg[W-1];
    n_ext   = SW'(src_n);
    dbl     = SW'(src_p) << 1;
    red1    = (dbl >= n_ext) ? dbl - n_ext : dbl;
    sum     = red1 + (src_bit ? SW'(src_a) : '0);
    red2    = (sum >= n_ext) ? sum - n_ext : sum;
    p_next  = W'(red2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      n_reg    <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else if (start) begin
      p_reg    <= p_next;
      a_reg    <= a;
      b_reg    <= b << 1;
      n_reg    <= n;
      cnt_reg  <= CW'(W - 1);
      done_reg <= (W == 1);
    end else if (cnt_reg != '0) begin
      p_reg    <= p_next;
      b_reg    <= b_reg << 1;
      cnt_reg  <= cnt_reg - CW'(1);
      done_reg <= (cnt_reg == CW'(1));
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign done = done_reg;
  assign p    = p_reg;

endmodule

// File: rtl/rsa_modexp_core.sv
// Constant-time left-to-right square-and-multiply: result = msg^exp mod modulus.
// RSA_RANGE_CHECK_EN adds an err output and rejects msg>=modulus or modulus<2.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  rsa_modexp_core_if.slave  bus
);
  localparam int BW = $clog2(W + 1);

  rsa_state_e    state_reg, state_next;
  logic [W-1:0]  acc_reg, msg_reg, exp_reg, n_reg, result_reg;
  logic [BW-1:0] bits_reg;

  logic          mm_start, mm_done;
  logic [W-1:0]  mm_a, mm_b, mm_n, mm_p, acc_new;

`ifdef RSA_RANGE_CHECK_EN
  logic          err_reg;
  logic          range_bad;
  assign range_bad = (bus.msg >= bus.modulus) || (bus.modulus < W'(2));
`endif

  rsa_modmul #(.W(W)) u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .n     (mm_n),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // The next product is launched on the same edge that retires the previous one,
  // so operands come straight from the multiplier output rather than acc_reg.
  always_comb begin
    state_next = state_reg;
    mm_start   = 1'b0;
    mm_a       = acc_reg;
    mm_b       = acc_reg;
    mm_n       = n_reg;
    acc_new    = exp_reg[W-1] ? mm_p : acc_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_SQR;
          mm_start   = 1'b1;
          mm_a       = W'(1);
          mm_b       = W'(1);
          mm_n       = bus.modulus;
`ifdef RSA_RANGE_CHECK_EN
          if (range_bad) begin
            state_next = ST_DONE;
            mm_start   = 1'b0;
          end
`endif
        end
      end
      ST_SQR: begin
        if (mm_done) begin
          state_next = ST_MUL;
          mm_start   = 1'b1;
          mm_a       = mm_p;
          mm_b       = msg_reg;
        end
      end
      ST_MUL: begin
        if (mm_done) begin
          if (bits_reg == BW'(1)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SQR;
            mm_start   = 1'b1;
            mm_a       = acc_new;
            mm_b       = acc_new;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      msg_reg    <= '0;
      exp_reg    <= '0;
      n_reg      <= '0;
      result_reg <= '0;
      bits_reg   <= '0;
`ifdef RSA_RANGE_CHECK_EN
      err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            acc_reg  <= W'(1);
            msg_reg  <= bus.msg;
            exp_reg  <= bus.exp;
            n_reg    <= bus.modulus;
            bits_reg <= BW'(W);
`ifdef RSA_RANGE_CHECK_EN
            err_reg  <= range_bad;
            if (range_bad) result_reg <= '0;
`endif
          end
        end
        ST_SQR: begin
          if (mm_done) acc_reg <= mm_p;
        end
        ST_MUL: begin
          // Product is always computed; it is kept only when the exponent bit is set
          if (mm_done) begin
            acc_reg  <= acc_new;
            exp_reg  <= exp_reg << 1;
            bits_reg <= bits_reg - BW'(1);
            if (bits_reg == BW'(1)) result_reg <= acc_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_reg != ST_IDLE);
  assign bus.done   = (state_reg == ST_DONE);
  assign bus.result = result_reg;
`ifdef RSA_RANGE_CHECK_EN
  assign bus.err    = err_reg;
`endif

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: directed vectors with hand-computed results plus a
// cycle-level reference model checked every cycle. RSA_RANGE_CHECK_EN adds err tests.
module tb_rsa_modexp_core;
  localparam int W   = 8;
  localparam int LAT = 2 * W * W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rsa_modexp_core_if #(.W(W)) bus ();

  rsa_modexp_core #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain repeated modular multiplication
  function automatic int model_exp(input int m, input int e, input int n);
    longint r;
    r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * m) % n;
    return int'(r);
  endfunction

  // Cycle-level model: accept when idle, done LAT cycles later (1 on range error)
  bit m_busy = 1'b0;
  int m_cnt = 0, m_lat = LAT, m_pend = 0, m_result = 0;
  bit m_err = 1'b0, m_perr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      m_result <= 0;
      m_err    <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == m_lat) begin
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == m_lat) begin
          m_result <= m_pend;
          m_err    <= m_perr;
        end
      end
    end else if (bus.start) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
`ifdef RSA_RANGE_CHECK_EN
      if (bus.msg >= bus.modulus || bus.modulus < 2) begin
        m_lat    <= 1;
        m_result <= 0;
        m_err    <= 1'b1;
      end else begin
        m_lat  <= LAT;
        m_pend <= model_exp(int'(bus.msg), int'(bus.exp), int'(bus.modulus));
        m_perr <= 1'b0;
      end
`else
      m_lat  <= LAT;
      m_pend <= (bus.modulus == '0) ? 0 :
                model_exp(int'(bus.msg), int'(bus.exp), int'(bus.modulus));
      m_perr <= 1'b0;
`endif
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    check("busy", int'(bus.busy), int'(m_busy));
    check("done", int'(bus.done), int'(m_busy && m_cnt == m_lat));
    check("result", int'(bus.result), m_result);
`ifdef RSA_RANGE_CHECK_EN
    if (bus.done) check("err", int'(bus.err), int'(m_err));
`endif
  end

  typedef struct {
    int m;
    int e;
    int n;
    int r;
  } vec_t;

  // Run one request; optional extra start pulses at cycles p1/p2 and in the done cycle
  task automatic run_op(input int m, input int e, input int n, input int expv,
                        input int explat, input int p1, input int p2,
                        input bit start_at_done, input string name);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.msg     = W'(m);
    bus.exp     = W'(e);
    bus.modulus = W'(n);
    while (!seen && k < LAT + 20) begin
      @(negedge clk);
      k++;
      if (bus.done) begin
        seen = 1'b1;
      end else if (k == p1 || k == p2) begin
        bus.start   = 1'b1;
        bus.msg     = 8'd3;
        bus.exp     = 8'd7;
        bus.modulus = 8'd35;
      end else begin
        bus.start   = 1'b0;
        bus.msg     = W'($urandom);
        bus.exp     = W'($urandom);
        bus.modulus = W'($urandom_range(255, 1));
      end
    end
    check({name, " latency"}, k, explat);
    check({name, " result"}, int'(bus.result), expv);
    $display("%s: m=%0d e=%0d n=%0d -> result=%0d after %0d cycles",
             name, m, e, n, bus.result, k);
    if (start_at_done) begin
      bus.start   = 1'b1;
      bus.msg     = 8'd5;
      bus.exp     = 8'd3;
      bus.modulus = 8'd7;
      @(negedge clk);
      bus.start = 1'b0;
      check({name, " start in done ignored"}, int'(bus.busy), 0);
    end else begin
      bus.start = 1'b0;
    end
  endtask

  vec_t vecs[$];

  initial begin
    bus.start   = 1'b0;
    bus.msg     = '0;
    bus.exp     = '0;
    bus.modulus = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset result", int'(bus.result), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    check("model 4^3%33", model_exp(4, 3, 33), 31);
    check("model 31^7%33", model_exp(31, 7, 33), 4);
    check("model 11^5%21", model_exp(11, 5, 21), 2);

    vecs.push_back('{4, 3, 33, 31});
    vecs.push_back('{31, 7, 33, 4});
    vecs.push_back('{2, 5, 21, 11});
    vecs.push_back('{11, 5, 21, 2});
    vecs.push_back('{4, 0, 33, 1});
    vecs.push_back('{0, 3, 33, 0});
    vecs.push_back('{0, 5, 1, 0});
    vecs.push_back('{32, 255, 33, 32});
    vecs.push_back('{254, 2, 255, 1});
    vecs.push_back('{2, 8, 251, 5});
    vecs.push_back('{200, 1, 201, 200});
    foreach (vecs[i])
      run_op(vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].r, LAT, -1, -1, 1'b0,
             $sformatf("vec%0d", i));

    // Starts while busy and in the done cycle are ignored
    run_op(4, 3, 33, 31, LAT, 10, 60, 1'b1, "busy_pulses");
    repeat (3) @(negedge clk);

    // Reset abort at cycle 50
    @(negedge clk);
    bus.start = 1'b1; bus.msg = 8'd4; bus.exp = 8'd3; bus.modulus = 8'd33;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (48) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort result", int'(bus.result), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      if (bus.done) check("abort no done", int'(bus.done), 0);
    end
    $display("abort: reset at cycle 50, busy=%0d result=%0d", bus.busy, bus.result);
    run_op(4, 3, 33, 31, LAT, -1, -1, 1'b0, "after_abort");

`ifdef RSA_RANGE_CHECK_EN
    run_op(40, 3, 33, 0, 1, -1, -1, 1'b0, "range_msg");
    check("range_msg err", int'(bus.err), 1);
    run_op(0, 3, 1, 0, 1, -1, -1, 1'b0, "range_n1");
    check("range_n1 err", int'(bus.err), 1);
    run_op(2, 5, 21, 11, LAT, -1, -1, 1'b0, "range_ok");
    check("range_ok err", int'(bus.err), 0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_core.md
RSA_MODEXP_CORE -- requirements
Module: rsa_modexp_core

Interface
REQ-001 Parameter W, default 8: operand width in bits for message, exponent, modulus and result.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 msg  input  W  message or ciphertext m; captured on accepting edge.
REQ-006 exp  input  W  exponent (e for encrypt, d for decrypt); captured on accepting edge.
REQ-007 modulus  input  W  modulus n = p*q; captured on accepting edge.
REQ-008 busy  output  1  high from accepting edge until the DONE cycle inclusive.
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 result  output  W  m^exp mod n; holds last value until next done.
REQ-011 err  output  1  error flag, qualified by done; exists only under the macro in REQ-027.

Function
REQ-012 Computes m^exp mod n by left-to-right square-and-multiply, MSB of exp first, all W bits processed.
REQ-013 Constant time: each bit runs a SQR phase and a MUL phase regardless of bit value; a MUL result is kept only if the bit is 1.
REQ-014 States are IDLE, SQR, MUL and DONE. Transitions: IDLE->SQR on start; SQR->MUL after W cycles; MUL->SQR after W cycles if bits remain, else MUL->DONE; DONE->IDLE unconditionally.
REQ-015 Accumulator initialised to 1 on the accepting edge.
REQ-016 Modular multiply is interleaved shift-add, one multiplier bit per cycle, W cycles per product. Each step computes acc=2*acc, subtracts n if the value is >=n, adds the operand, and subtracts n if the value is >=n.
REQ-017 Internal sums are W+2 bits wide; no intermediate value reaches or exceeds 2n before reduction.
REQ-018 Latency: done is high exactly 2*W*W+1 cycles after the accepting edge (129 for W=8).
REQ-019 start while busy=1 is ignored; a start in the DONE cycle is ignored.
REQ-020 exp=0 yields result=1 mod n; n=1 yields result=0.
REQ-021 Without the REQ-027 macro, msg>=n or n=0 gives an unspecified result, but done still occurs at the REQ-018 latency.
REQ-022 Input ports may change freely after the accepting edge without effect.

Reset
REQ-023 rst_n low asynchronously forces IDLE, busy=0, done=0, result=0 and err=0.
REQ-024 Reset mid-operation aborts the operation with no done pulse; the first start after release is accepted normally.

Configuration
REQ-025 The range check is the only compile-time option.
REQ-026 Macro name is RSA_RANGE_CHECK_EN.
REQ-027 With RSA_RANGE_CHECK_EN defined, if msg>=modulus or modulus<2 at the accepting edge, the FSM goes directly to DONE: done=1, err=1, result=0 one cycle later, and busy is high for that single cycle. Otherwise err=0 at done.
REQ-028 With the macro undefined, the err port and the check logic are absent, and REQ-021 applies.

Structure
REQ-029 Shared package rsa_pkg holds: the state enum type, RSA_W=8, the RSA_LATENCY function/constant (2*W*W+1), and the constants shared with the key-generation multiplier path.
REQ-030 One sub-module, rsa_modmul, performs the W-cycle interleaved modular multiply (start/done handshake, operands a<n and b, modulus n). The core instantiates it once and reuses it for SQR and MUL.

Verification
REQ-031 Encrypt: n=33, e=3, m=4 -> done at cycle 129, result=31. Decrypt: n=33, d=7, m=31 -> result=4.
REQ-032 Encrypt: n=21, e=5, m=2 -> result=11. Decrypt: n=21, d=5, m=11 -> result=2.
REQ-033 Edge cases: exp=0, n=33, m=4 -> result=1. m=0, exp=3 -> result=0. n=1 -> result=0.
REQ-034 Busy handling: start pulsed at cycles 10 and 60 of an operation -> both ignored, exactly one done at 129, result unchanged by the extra pulses.
REQ-035 Reset abort: rst_n low at cycle 50 -> busy=0 and result=0 immediately, no done; a new request (n=33, e=3, m=4) then gives 31.
REQ-036 Range check (RSA_RANGE_CHECK_EN defined): m=40, n=33 -> done one cycle after accept, err=1, result=0. n=1 -> err=1. Valid inputs -> err=0.
